// File: rtl/mem_loader.sv
// Byte-stream loader for the single-port BRAM.
// Assembles big-endian words, writes them to consecutive addresses, and keeps a running checksum.
module mem_loader #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [AddrWidth-1:0] i_base_addr,
  input  logic [AddrWidth:0]   i_word_count,
  input  logic [7:0]           i_byte_in,
  input  logic                 i_byte_valid,
  output logic                 o_byte_ready,
  output logic [DataWidth-1:0] o_mem_din,
  output logic [AddrWidth-1:0] o_mem_address,
  output logic                 o_mem_write_en,
  output logic                 o_mem_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DataWidth-1:0] o_checksum
);

  localparam int BytesPerWord = DataWidth / 8;
  localparam int IdxWidth     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IdxWidth-1:0]   r_byte_idx;
  logic [DataWidth-1:0]  r_word;
  logic [AddrWidth:0]    r_remaining;
  logic [DataWidth-1:0]  r_mem_din;
  logic [AddrWidth-1:0]  r_mem_address;
  logic [DataWidth-1:0]  r_checksum;
  logic                  r_byte_ready;
  logic                  r_mem_en;
  logic                  r_mem_write_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_last_byte;
  logic [DataWidth-1:0]  w_shifted;

  assign w_accept    = (r_state == S_COLLECT) && i_byte_valid && r_byte_ready;
  assign w_last_byte = (r_byte_idx == IdxWidth'(BytesPerWord - 1));
  assign w_shifted   = (r_word << 8) | DataWidth'(i_byte_in);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (i_word_count == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_accept && w_last_byte) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next = (r_remaining == (AddrWidth+1)'(1)) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they are already valid at the BRAM's negedge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byte_idx     <= '0;
      r_word         <= '0;
      r_remaining    <= '0;
      r_mem_din      <= '0;
      r_mem_address  <= '0;
      r_checksum     <= '0;
      r_byte_ready   <= 1'b0;
      r_mem_en       <= 1'b1;
      r_mem_write_en <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_byte_ready   <= (w_next == S_COLLECT);
      r_mem_en       <= (w_next != S_WRITE);
      r_mem_write_en <= (w_next != S_WRITE);
      r_busy         <= (w_next == S_COLLECT) || (w_next == S_WRITE);
      r_done         <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mem_address <= i_base_addr;
            r_remaining   <= i_word_count;
            r_checksum    <= '0;
            r_byte_idx    <= '0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_word <= w_shifted;
            if (w_last_byte) begin
              r_byte_idx <= '0;
              r_mem_din  <= w_shifted;
            end else begin
              r_byte_idx <= r_byte_idx + IdxWidth'(1);
            end
          end
        end
        S_WRITE: begin
          r_checksum    <= r_checksum + r_mem_din;
          r_mem_address <= r_mem_address + AddrWidth'(1);
          r_remaining   <= r_remaining - (AddrWidth+1)'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_byte_ready   = r_byte_ready;
  assign o_mem_din      = r_mem_din;
  assign o_mem_address  = r_mem_address;
  assign o_mem_write_en = r_mem_write_en;
  assign o_mem_en       = r_mem_en;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_checksum     = r_checksum;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: the stimulus side pushes expected writes and checksums,
// a negedge monitor pops and compares them against the loader outputs and a BRAM model.
module tb_mem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        startReq;
  logic [7:0]  baseAddr;
  logic [8:0]  wordCount;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic [15:0] memDIn;
  logic [7:0]  memAddress;
  logic        memWriteEn;
  logic        memEn;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  mem_loader #(.AddrWidth(8), .DataWidth(16)) dut (
    .i_clk          (clock),
    .i_rst          (reset),
    .i_start        (startReq),
    .i_base_addr    (baseAddr),
    .i_word_count   (wordCount),
    .i_byte_in      (byteIn),
    .i_byte_valid   (byteValid),
    .o_byte_ready   (byteReady),
    .o_mem_din      (memDIn),
    .o_mem_address  (memAddress),
    .o_mem_write_en (memWriteEn),
    .o_mem_en       (memEn),
    .o_busy         (busy),
    .o_done         (done),
    .o_checksum     (checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] sum;
    bit          zero;
  } done_t;

  wr_t         expWrites[$];
  done_t       expDone[$];
  logic [15:0] stimWords[$];
  logic [7:0]  stimBytes[$];
  logic [15:0] bram [256];
  bit          prevWrite;
  int          checks   = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every BRAM write and every Done pulse is matched against the scoreboard queues.
  always @(negedge clock) begin : monitor
    wr_t   e;
    done_t d;
    if (reset) begin
      prevWrite = 1'b0;
    end else begin
      if (!memEn) begin
        checkOutput("write_en_pair", {31'd0, memWriteEn}, 32'd0);
        checkOutput("ready_in_write", {31'd0, byteReady}, 32'd0);
        bram[memAddress] = memDIn;
        if (expWrites.size() == 0) begin
          checkOutput("unexpected_write", {24'd0, memAddress}, 32'hFFFF_FFFF);
        end else begin
          e = expWrites.pop_front();
          checkOutput("write_addr", {24'd0, memAddress}, {24'd0, e.addr});
          checkOutput("write_data", {16'd0, memDIn}, {16'd0, e.data});
        end
      end
      if (done) begin
        checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
        if (expDone.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          d = expDone.pop_front();
          checkOutput("done_checksum", {16'd0, checksum}, {16'd0, d.sum});
          if (!d.zero) checkOutput("done_after_write", {31'd0, prevWrite}, 32'd1);
        end
      end
      prevWrite = !memEn;
    end
  end

  task automatic pulseStart(input logic [7:0] base, input int count);
    @(negedge clock);
    startReq  = 1'b1;
    baseAddr  = base;
    wordCount = 9'(count);
    @(posedge clock);
    @(negedge clock);
    startReq = 1'b0;
  endtask

  // Offers stimBytes one at a time; optional 3-cycle gaps and a Start pulse mid-load.
  task automatic sendBytes(input bit stall, input bit midStart);
    int t;
    for (int i = 0; i < stimBytes.size(); i++) begin
      @(negedge clock);
      if (stall && i > 0) begin
        byteValid = 1'b0;
        for (int s = 0; s < 3; s++) begin
          if (i % 2 == 1) checkOutput("ready_in_stall", {31'd0, byteReady}, 32'd1);
          @(negedge clock);
        end
      end
      if (midStart && i == 3) begin
        byteValid = 1'b0;
        startReq  = 1'b1;
        baseAddr  = 8'h80;
        wordCount = 9'd5;
        @(posedge clock);
        @(negedge clock);
        startReq = 1'b0;
      end
      byteIn    = stimBytes[i];
      byteValid = 1'b1;
      t = 0;
      while (!byteReady && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (t >= 50) begin
        checkOutput("ready_timeout", 32'd0, 32'd1);
        byteValid = 1'b0;
        return;
      end
      @(posedge clock);
    end
    @(negedge clock);
    byteValid = 1'b0;
  endtask

  task automatic waitDone();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) checkOutput("done_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  // Reference model: word k goes to (base+k) mod 256; checksum is the 16-bit sum of all words.
  task automatic applyStimulus(input logic [7:0] base, input int count, input bit stall, input bit midStart);
    logic [15:0] sum = 16'd0;
    logic [15:0] w;
    wr_t         e;
    done_t       d;
    while (stimWords.size() < count) stimWords.push_back(16'($urandom));
    stimBytes.delete();
    for (int k = 0; k < count; k++) begin
      w = stimWords[k];
      stimBytes.push_back(w[15:8]);
      stimBytes.push_back(w[7:0]);
      e.addr = 8'(int'(base) + k);
      e.data = w;
      expWrites.push_back(e);
      sum += w;
    end
    d.sum  = sum;
    d.zero = (count == 0);
    expDone.push_back(d);
    pulseStart(base, count);
    if (count == 0) begin
      checkOutput("zero_done_timing", {31'd0, done}, 32'd1);
      @(negedge clock);
    end else begin
      sendBytes(stall, midStart);
      waitDone();
    end
    checkOutput("busy_after_load", {31'd0, busy}, 32'd0);
    checkOutput("checksum_hold", {16'd0, checksum}, {16'd0, sum});
    checkOutput("addr_hold", {24'd0, memAddress}, {24'd0, 8'(int'(base) + count)});
    stimWords.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    startReq  = 1'b0;
    baseAddr  = 8'h00;
    wordCount = 9'd0;
    byteIn    = 8'h00;
    byteValid = 1'b0;
    for (int i = 0; i < 256; i++) bram[i] = 16'h0000;
    #1;
    checkOutput("reset_mem_en", {31'd0, memEn}, 32'd1);
    checkOutput("reset_write_en", {31'd0, memWriteEn}, 32'd1);
    checkOutput("reset_ready", {31'd0, byteReady}, 32'd0);
    checkOutput("reset_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("reset_checksum", {16'd0, checksum}, 32'd0);
    checkOutput("reset_addr_din", {8'd0, memAddress, memDIn}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    $display("[TB] basic load");
    stimWords = '{16'h1234, 16'hABCD};
    applyStimulus(8'h10, 2, 1'b0, 1'b0);
    checkOutput("basic_checksum", {16'd0, checksum}, 32'h0000_BE01);
    checkOutput("basic_mem10", {16'd0, bram[8'h10]}, 32'h0000_1234);
    checkOutput("basic_mem11", {16'd0, bram[8'h11]}, 32'h0000_ABCD);

    $display("[TB] stalled source");
    bram[8'h10] = 16'h0000;
    bram[8'h11] = 16'h0000;
    stimWords = '{16'h1234, 16'hABCD};
    applyStimulus(8'h10, 2, 1'b1, 1'b0);
    checkOutput("stall_mem10", {16'd0, bram[8'h10]}, 32'h0000_1234);
    checkOutput("stall_mem11", {16'd0, bram[8'h11]}, 32'h0000_ABCD);

    $display("[TB] zero count");
    applyStimulus(8'h42, 0, 1'b0, 1'b0);
    checkOutput("zero_checksum", {16'd0, checksum}, 32'd0);

    $display("[TB] address wrap");
    stimWords = '{16'h0001, 16'h0002};
    applyStimulus(8'hFF, 2, 1'b0, 1'b0);
    checkOutput("wrap_memFF", {16'd0, bram[8'hFF]}, 32'h0000_0001);
    checkOutput("wrap_mem00", {16'd0, bram[8'h00]}, 32'h0000_0002);
    checkOutput("wrap_checksum", {16'd0, checksum}, 32'h0000_0003);

    $display("[TB] start while busy");
    bram[8'h80] = 16'hDEAD;
    applyStimulus(8'h30, 3, 1'b0, 1'b1);
    checkOutput("busy_start_mem80", {16'd0, bram[8'h80]}, 32'h0000_DEAD);

    $display("[TB] reset mid-load");
    begin
      wr_t e;
      stimBytes = '{8'h5A, 8'hA5, 8'h77};
      e.addr = 8'h20;
      e.data = 16'h5AA5;
      expWrites.push_back(e);
      pulseStart(8'h20, 3);
      sendBytes(1'b0, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("rst_mem_en", {31'd0, memEn}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_ready", {31'd0, byteReady}, 32'd0);
      checkOutput("rst_checksum", {16'd0, checksum}, 32'd0);
      checkOutput("rst_word1_kept", {16'd0, bram[8'h20]}, 32'h0000_5AA5);
      checkOutput("rst_pending", expWrites.size(), 32'd0);
      @(negedge clock);
      reset = 1'b0;
    end
    applyStimulus(8'h20, 2, 1'b0, 1'b0);

    $display("[TB] randomized loads");
    for (int n = 0; n < 8; n++) begin
      applyStimulus(8'($urandom), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] full-memory wrap");
    applyStimulus(8'h05, 256, 1'b0, 1'b0);

    checkOutput("writes_drained", expWrites.size(), 32'd0);
    checkOutput("dones_drained", expDone.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
